adder_accum: RTL
================

ADDER_ACCUM -- requirements
Module: adder_accum

Interface
- REQ-001: Parameter Bit, default 15, is the data/accumulator width in bits.
- REQ-002: Parameter CNT_W, default 8, is the beat-counter width in bits.
- REQ-003: Port clk, input, 1, is the single clock; all state updates on the rising edge.
- REQ-004: Port rst_n, input, 1, is the asynchronous, active-low reset.
- REQ-005: Port in_valid, input, 1, means the upstream operand beat is valid.
- REQ-006: Port in_ready, output, 1, means the block accepts a beat this cycle.
- REQ-007: Port in_data, input, Bit, is the operand to add.
- REQ-008: Port in_last, input, 1, marks the final beat of a group; sampled only on accept.
- REQ-009: Port out_valid, output, 1, means the group result is valid.
- REQ-010: Port out_ready, input, 1, means downstream takes the result.
- REQ-011: Port out_sum, output, Bit, is the group sum.
- REQ-012: Port out_ovf, output, 1, is the sticky carry-out flag for the group.
- REQ-013: Port out_count, output, CNT_W, is the number of beats in the group, saturating.

Function
- REQ-014: Accept SHALL occur when in_valid and in_ready are both high on a rising edge; transfer SHALL occur when out_valid and out_ready are both high.
- REQ-015: The FSM SHALL have states IDLE, ACCUM and HOLD.
- REQ-016: In IDLE and ACCUM, in_ready SHALL be 1 and out_valid 0; in HOLD, in_ready SHALL be 0 and out_valid 1; both are decoded from state only.
- REQ-017: An accept in IDLE SHALL load acc with in_data, set count to 1 and clear ovf.
- REQ-018: An accept in ACCUM SHALL set acc to the Bit-wide sum of acc and in_data, OR carry-out into ovf, and increment count, holding it at 2^CNT_W-1.
- REQ-019: An accept with in_last=0 SHALL go to ACCUM; with in_last=1 it SHALL go to HOLD.
- REQ-020: The result SHALL appear on out_sum, out_ovf and out_count the cycle after the last beat is accepted (latency 1).
- REQ-021: In HOLD, out_sum, out_ovf and out_count SHALL stay stable until transfer.
- REQ-022: On transfer, the FSM SHALL go to IDLE and clear acc, ovf and count.
- REQ-023: A group always has a one-cycle input bubble after in_last; the block SHALL NOT accept in the transfer cycle.
- REQ-024: With no accept in IDLE or ACCUM, state and registers SHALL hold.

Reset
- REQ-025: Asserting rst_n low at any time SHALL immediately force IDLE, acc=0, ovf=0, count=0, out_valid=0 and in_ready=1.
- REQ-026: Any partial group in progress at reset SHALL be discarded.
- REQ-027: Deassertion is synchronised externally; the block samples no input on the release edge beyond normal operation.

Configuration
- REQ-028: Macro ADDER_ACCUM_SATURATE_EN defined: on any carry-out, acc SHALL become all-ones and remain all-ones for the rest of the group; ovf is set.
- REQ-029: Macro ADDER_ACCUM_SATURATE_EN undefined: acc SHALL wrap modulo 2^Bit; ovf is still set.

Structure
- REQ-030: Package adder_accum_pkg SHALL hold the state encoding (IDLE=0, ACCUM=1, HOLD=2) and the default widths.
- REQ-031: The addition SHALL use one instance of the existing ripple adder adder_with_parametr (Bit-wide, carry-in 0); no other sub-modules.

Verification (Bit=15, CNT_W=8 unless noted)
- REQ-032: Beats 100, 200, 300(last) -> next cycle out_valid=1, out_sum=600, out_count=3, out_ovf=0.
- REQ-033: Beats 0x7FFF, 0x0002(last) -> wrap build gives out_sum=0x0001 with ovf=1; SATURATE build gives out_sum=0x7FFF with ovf=1.
- REQ-034: Single beat 0x1234 with in_last in IDLE -> out_sum=0x1234, out_count=1; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
- REQ-035: rst_n pulsed low after 2 of 4 beats -> immediately IDLE, in_ready=1; the next group 5, 6(last) gives 11.
- REQ-036: CNT_W=2, 5 beats of 1 -> out_count=3, out_sum=5.

Source files
------------

// File: rtl/adder_accum_pkg.sv
// adder_accum_pkg: shared FSM state encoding and default widths for the
// grouping accumulator.
//   state_t      - FSM encoding (IDLE=0, ACCUM=1, HOLD=2)
//   BIT_DEF      - default data/accumulator width
//   CNT_W_DEF    - default beat-counter width
package adder_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int BIT_DEF   = 15;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/adder_with_parametr.sv
// adder_with_parametr: plain ripple-carry adder.
// Ports:
//   a, b  - Bit-wide operands
//   cin   - carry in
//   sum   - Bit-wide sum
//   cout  - carry out of the top bit
module adder_with_parametr #(
  parameter int Bit = 15
) (
  input  logic [Bit-1:0] a,
  input  logic [Bit-1:0] b,
  input  logic           cin,
  output logic [Bit-1:0] sum,
  output logic           cout
);

  logic [Bit:0] carry;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < Bit; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[Bit];

endmodule

// File: rtl/adder_accum.sv
// adder_accum: sums a group of valid/ready operand beats terminated by
// in_last and presents the sum, sticky carry flag and beat count until the
// downstream takes it.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   in_valid/in_ready/in_data/in_last - operand beat handshake
//   out_valid/out_ready           - result handshake
//   out_sum, out_ovf, out_count   - group sum, sticky carry-out, beat count
// Build option: ADDER_ACCUM_SATURATE_EN pins the accumulator at all-ones
// after the first carry-out of a group instead of wrapping.
//
// state | meaning
// IDLE  | waiting for first beat of a group, registers cleared
// ACCUM | at least one beat taken, group still open
// HOLD  | group closed, result offered downstream
module adder_accum
  import adder_accum_pkg::*;
#(
  parameter int Bit   = BIT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Bit-1:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Bit-1:0]   out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  state_t           state, state_nxt;
  logic [Bit-1:0]   acc, add_sum, acc_nxt;
  logic             ovf, add_cout;
  logic [CNT_W-1:0] count;
  logic             accept, transfer;

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  adder_with_parametr #(.Bit(Bit)) u_adder (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef ADDER_ACCUM_SATURATE_EN
  // once a carry has been seen the group stays pinned at full scale
  assign acc_nxt = (add_cout | ovf) ? {Bit{1'b1}} : add_sum;
`else
  assign acc_nxt = add_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) state_nxt = in_last ? HOLD : ACCUM;
      HOLD:        if (out_ready) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state == HOLD) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (transfer) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (accept && state == IDLE) begin
      acc   <= in_data;
      ovf   <= 1'b0;
      count <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (accept) begin
      acc <= acc_nxt;
      ovf <= ovf | add_cout;
      if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
    end
  end

  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = count;

endmodule
